// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: round-robin arbiter sharing one valid/ready/last data
// channel between N requesters and a single slave. One requester owns the
// channel at a time; ownership is released on a last beat or after
// MAX_BURST beats, followed by one mandatory idle cycle.
module axi_rr_arbiter #(
    parameter int N         = 4,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [N*DW-1:0]      req_data,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_ready,
    output logic                 m_valid,
    output logic [DW-1:0]        m_data,
    output logic                 m_last,
    output logic [$clog2(N)-1:0] m_src,
    input  logic                 m_ready,
    output logic [N-1:0]         grant,
    output logic                 busy
);

    localparam int SW = $clog2(N);
    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_GRANT = 1'b1;
    localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [SW-1:0] LW_INIT  = SW'(N - 1);

    logic [0:0]    state_r;
    logic [N-1:0]  grant_r;
    logic [SW-1:0] src_r;
    logic [CW-1:0] beat_cnt_r;
    logic [SW-1:0] last_winner_r;

    logic          found_s;
    logic [SW-1:0] winner_s;
    logic          beat_s;
    logic [CW-1:0] cnt_inc_s;
    logic          release_s;

    assign grant     = grant_r;
    assign m_src     = src_r;
    assign busy      = (state_r == ST_GRANT);
    assign beat_s    = m_valid & m_ready;
    assign cnt_inc_s = beat_cnt_r + CNT_ONE;
    assign release_s = beat_s & (m_last | (cnt_inc_s == CNT_MAX));

    // Round-robin search: first valid requester after the last winner, wrapping.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        for (int k = 1; k <= N; k++) begin
            if (!found_s && req_valid[(int'(last_winner_r) + k) % N]) begin
                found_s  = 1'b1;
                winner_s = SW'((int'(last_winner_r) + k) % N);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Combinational pass-through of the granted requester; zeros while idle.
    always_comb begin
        m_valid   = 1'b0;
        m_data    = '0;
        m_last    = 1'b0;
        req_ready = '0;
        if (state_r == ST_GRANT) begin
            m_valid   = req_valid[src_r];
            m_data    = req_data[int'(src_r) * DW +: DW];
            m_last    = req_last[src_r];
            req_ready = grant_r & {N{m_ready}};
        end else begin
            m_valid   = 1'b0;
        end
    end

    // Grant state machine, beat counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            grant_r       <= '0;
            src_r         <= '0;
            beat_cnt_r    <= '0;
            last_winner_r <= LW_INIT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        state_r    <= ST_GRANT;
                        grant_r    <= ONE_HOT0 << winner_s;
                        src_r      <= winner_s;
                        beat_cnt_r <= '0;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        state_r       <= ST_IDLE;
                        grant_r       <= '0;
                        beat_cnt_r    <= '0;
                        last_winner_r <= src_r;
                    end else if (beat_s) begin
                        beat_cnt_r    <= cnt_inc_s;
                    end else begin
                        beat_cnt_r    <= beat_cnt_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    grant_r    <= '0;
                    beat_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Testbench for axi_rr_arbiter: requester stream models drive the DUT, the
// stimulus pushes hand-computed expected beats into a scoreboard queue, and
// a monitor pops and compares on every accepted beat.
module tb_axi_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic            m_valid;
    logic [DW-1:0]   m_data;
    logic            m_last;
    logic [1:0]      m_src;
    logic            m_ready = 1'b1;
    logic [N-1:0]    grant;
    logic            busy;

    axi_rr_arbiter #(.N(N), .DW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_src(m_src),
        .m_ready(m_ready), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // Requester stream model state
    int          rem[N];
    int          bcnt[N];
    logic [31:0] base[N];
    logic        hold[N];
    logic        last_every[N];
    logic        last_final[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input int src, input logic [31:0] data, input logic last);
        exp_t e;
        e.src  = 2'(src);
        e.data = data;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = (rem[i] != 0) && !hold[i];
            req_data[i*DW +: DW]  = base[i] + 32'(bcnt[i]);
            req_last[i]           = last_every[i] || (last_final[i] && rem[i] == 1);
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; bcnt[i] = 0; base[i] = 32'h0;
            hold[i] = 1'b0; last_every[i] = 1'b0; last_final[i] = 1'b0;
        end
        drive();
    endtask

    // One clock: capture accepted beats before the edge, advance streams after it.
    task automatic step();
        logic [N-1:0] took;
        @(negedge clk);
        took = (reset) ? '0 : (req_valid & req_ready);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (took[i]) begin
                rem[i]--;
                bcnt[i]++;
            end
        end
        drive();
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk({name, "_timeout"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        repeat (3) step();
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_m_valid", 64'(m_valid), 64'h0);
        chk("rst_m_data", 64'(m_data), 64'h0);
        chk("rst_m_last", 64'(m_last), 64'h0);
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_m_src", 64'(m_src), 64'h0);
        reset = 1'b0;
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {62'h0, m_src}, 64'hFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("beat_src", 64'(m_src), 64'(e.src));
                chk("beat_data", 64'(m_data), 64'(e.data));
                chk("beat_last", 64'(m_last), 64'(e.last));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int order[5];
        order = '{0, 1, 2, 3, 0};

        // Reset and single requester
        do_reset();
        rem[2] = 1; base[2] = 32'hA5A5_0001; last_final[2] = 1'b1; m_ready = 1'b1;
        push(2, 32'hA5A5_0001, 1'b1);
        drive(); #1;
        chk("t1_idle_busy", 64'(busy), 64'h0);
        chk("t1_idle_m_valid", 64'(m_valid), 64'h0);
        step();
        chk("t1_grant", 64'(grant), 64'h4);
        chk("t1_m_src", 64'(m_src), 64'h2);
        chk("t1_m_valid", 64'(m_valid), 64'h1);
        chk("t1_req_ready", 64'(req_ready), 64'h4);
        step();
        chk("t1_released", 64'(busy), 64'h0);
        chk("t1_sb_empty", 64'(sb.size()), 64'h0);

        // Round-robin fairness with single-beat bursts
        do_reset();
        for (int i = 0; i < N; i++) begin
            rem[i] = 3; base[i] = 32'h1000_0000 * (i + 1); last_every[i] = 1'b1;
        end
        for (int k = 0; k < 5; k++) push(order[k], 32'h1000_0000 * (order[k] + 1) + ((k == 4) ? 32'd1 : 32'd0), 1'b1);
        drive(); #1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_grant", 64'(grant), 64'(4'b0001 << order[k]));
            step();
            chk("rr_gap", 64'(busy), 64'h0);
        end
        clear_reqs();
        wait_done("rr");

        // Burst cap: requester 1 ten beats, requester 3 four beats
        rem[1] = 10; base[1] = 32'h0000_1100; last_final[1] = 1'b1;
        rem[3] = 4;  base[3] = 32'h0000_3300;
        for (int b = 0; b < 4; b++)  push(1, 32'h0000_1100 + 32'(b), 1'b0);
        for (int b = 0; b < 4; b++)  push(3, 32'h0000_3300 + 32'(b), 1'b0);
        for (int b = 4; b < 10; b++) push(1, 32'h0000_1100 + 32'(b), (b == 9) ? 1'b1 : 1'b0);
        drive(); #1;
        wait_done("cap");
        clear_reqs();

        // Backpressure on requester 0
        rem[0] = 3; base[0] = 32'h1234_5678; last_final[0] = 1'b1; m_ready = 1'b0;
        push(0, 32'h1234_5678, 1'b0);
        push(0, 32'h1234_5679, 1'b0);
        push(0, 32'h1234_567A, 1'b1);
        drive(); #1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_grant", 64'(grant), 64'h1);
            chk("bp_m_valid", 64'(m_valid), 64'h1);
            chk("bp_m_data", 64'(m_data), 64'h1234_5678);
            chk("bp_req_ready", 64'(req_ready), 64'h0);
        end
        m_ready = 1'b1; #1;
        chk("bp_ready_back", 64'(req_ready), 64'h1);
        wait_done("bp");
        clear_reqs();

        // Valid dropout: requester 0 granted, requester 2 waiting
        do_reset();
        rem[0] = 3; base[0] = 32'h0000_0A00; last_final[0] = 1'b1;
        rem[2] = 1; base[2] = 32'h0000_0C00; last_final[2] = 1'b1;
        push(0, 32'h0000_0A00, 1'b0);
        push(0, 32'h0000_0A01, 1'b0);
        push(0, 32'h0000_0A02, 1'b1);
        push(2, 32'h0000_0C00, 1'b1);
        drive(); #1;
        step();
        chk("drop_grant", 64'(grant), 64'h1);
        step();
        hold[0] = 1'b1; drive(); #1;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) step();
            chk("drop_hold_grant", 64'(grant), 64'h1);
            chk("drop_m_valid", 64'(m_valid), 64'h0);
        end
        hold[0] = 1'b0; drive(); #1;
        chk("drop_resume", 64'(m_valid), 64'h1);
        wait_done("drop");
        clear_reqs();

        // Reset mid-burst on requester 3
        rem[3] = 3; base[3] = 32'h0000_3D00; last_final[3] = 1'b1;
        push(3, 32'h0000_3D00, 1'b0);
        push(3, 32'h0000_3D01, 1'b0);
        drive(); #1;
        repeat (3) step();
        chk("mid_grant", 64'(grant), 64'h8);
        reset = 1'b1;
        step();
        chk("mid_rst_grant", 64'(grant), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_m_valid", 64'(m_valid), 64'h0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'h0);
        chk("mid_rst_m_src", 64'(m_src), 64'h0);
        chk("mid_rst_sb", 64'(sb.size()), 64'h0);
        reset = 1'b0;
        clear_reqs();
        rem[2] = 1; base[2] = 32'h0000_2E00; last_final[2] = 1'b1;
        rem[3] = 1; base[3] = 32'h0000_3E00; last_final[3] = 1'b1;
        push(2, 32'h0000_2E00, 1'b1);
        push(3, 32'h0000_3E00, 1'b1);
        drive(); #1;
        step();
        chk("post_rst_grant", 64'(grant), 64'h4);
        wait_done("post_rst");

        chk("final_sb_empty", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_rr_arbiter.md
# axi_rr_arbiter

Round-robin arbiter that shares one valid/ready data channel between N requesting masters and a single slave. Each requester presents a valid/data/last stream. The arbiter grants one requester at a time, passes its beats through to the slave, and releases the grant on the last beat or after MAX_BURST beats. It sits between the master instances and the slave on the shared 32-bit transfer path.

## Interface
- N, 4, number of requesters (2..8)
- DW, 32, data width
- MAX_BURST, 4, beats allowed per grant before forced release (>=1)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  N  per-requester valid
- req_data  in  N*DW  requester i data at bits [i*DW +: DW]
- req_last  in  N  per-requester last-beat flag, qualified by req_valid
- req_ready  out  N  per-requester ready
- m_valid  out  1  valid to slave
- m_data  out  DW  data to slave
- m_last  out  1  last flag to slave
- m_src  out  clog2(N)  index of the granted requester
- m_ready  in  1  ready from slave
- grant  out  N  one-hot current grant, all zero when idle
- busy  out  1  high while a grant is held

## Operation
- Two states:
  - IDLE: no grant.
  - GRANT: one requester owns the channel.
- In IDLE, the arbiter searches each cycle for the first asserted req_valid, starting at index (last_winner+1) mod N and wrapping.
  - If one is found, it registers grant[w] = 1, m_src = w, and state = GRANT for the next cycle.
  - If none is found, it stays in IDLE.
- In GRANT (winner g), the datapath is combinational:
  - m_valid = req_valid[g], m_data = req_data[g], m_last = req_last[g].
  - req_ready[g] = m_ready. All other req_ready are 0.
- In IDLE, m_valid = 0, m_last = 0, m_data = 0, and all req_ready = 0.
- A beat is a cycle with m_valid && m_ready. The beat counter increments per beat and is cleared on entry to GRANT.
- Release condition: a beat where m_last = 1, or a beat that makes the count equal MAX_BURST.
- On release:
  - grant clears to 0 and state returns to IDLE on the next edge.
  - last_winner is set to g.
  - The beat counter clears.
- If the granted requester drops req_valid mid-grant, the grant is held and m_valid follows it low. There is no timeout and no rotation.
- The beat counter width is clog2(MAX_BURST+1). The count never exceeds MAX_BURST.
- busy = (state == GRANT).

## Timing
- Reset values:
  - state IDLE, grant 0, m_src 0, busy 0, beat count 0, last_winner N-1 (so requester 0 has first priority).
  - Derived outputs: m_valid 0, req_ready 0, m_data 0, m_last 0.
- Request-to-grant latency:
  - req_valid rising in cycle t while IDLE gives grant/m_valid in cycle t+1.
  - req_ready[g] is high from t+1 whenever m_ready is high.
- Release gap: the beat at cycle t releases, the arbiter is IDLE at t+1, and the next grant is visible at t+2. This dead cycle is mandatory even with requests pending.
- Simultaneous requests resolve in one IDLE cycle by round-robin order. No requester waits more than N-1 grants.
- Reset asserted mid-grant:
  - Takes effect on that edge and returns all reset values.
  - An in-flight beat at that edge is not counted.
  - last_winner reverts to N-1.
- m_ready low holds the beat: data, valid and count are unchanged, and the grant is held.
- MAX_BURST = 1 releases after every beat.

## Test plan
- Reset and single requester:
  - Hold reset 3 cycles; all outputs must be 0 and grant 0.
  - Then req_valid = 4'b0100 with data 0xA5A5_0001 and last = 1, m_ready = 1.
  - Required: grant = 4'b0100, m_src = 2, m_valid high one cycle after the request, one beat, IDLE on the next cycle.
- Round-robin fairness:
  - All four valid continuously, each burst 1 beat with last = 1, m_ready = 1.
  - Required: grant order 0,1,2,3,0; each grant 1 cycle followed by 1 idle cycle.
- Burst cap:
  - Requester 1 sends 10 beats with last = 0, requester 3 is also valid, MAX_BURST = 4.
  - Required: 4 beats from 1, then 4 from 3, then 4 from 1 again; m_src alternates 1,3,1.
- Backpressure:
  - During a grant, m_ready is low for 3 cycles with data 0x1234_5678 presented.
  - Required: m_data stable, req_ready low, beat count unchanged; one beat completes when m_ready returns.
- Valid dropout:
  - Granted requester 0 deasserts valid for 2 cycles mid-burst while requester 2 is valid.
  - Required: grant stays on 0, m_valid low for those 2 cycles, no switch to 2.
- Reset mid-burst:
  - Assert reset after 2 of 3 beats of requester 3.
  - Required: the next cycle is fully reset; after release, simultaneous requests from 2 and 3 grant requester 2 first (priority restarts at 0).
